timer_step_sequencer: RTL
=========================

Name: timer_step_sequencer

Overview:
Avalon-MM master that programs and sequences the 16-bit-slave interval timer through a table of up to NUM_STEPS 32-bit periods. Each step runs the timer one-shot, waits for its irq, clears the timeout status, pulses step_event and advances; the table repeats when looping is enabled. Sits between the host control registers and the timer slave port, replacing software interrupt handling for periodic stimulus and sampling schedules.

Parameters:
NUM_STEPS, 8, table depth (2..16)
IDX_W, 3, index width, equals clog2(NUM_STEPS)

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
cfg_we  in  1  table write strobe
cfg_index  in  IDX_W  table entry written
cfg_period  in  32  period value (timer load value)
seq_len  in  IDX_W+1  steps per pass, latched on start
loop_en  in  1  restart at entry 0 after last step, latched on start
start  in  1  start pulse
stop  in  1  abort pulse
busy  out  1  sequence active
step_event  out  1  one-cycle pulse per completed step
step_index  out  IDX_W  index of completed or current step
done  out  1  one-cycle pulse, pass finished with loop_en=0
aborted  out  1  one-cycle pulse, abort completed
remaining  out  32  count remaining at abort (see Optional Feature)
tm_address  out  3  timer slave address
tm_chipselect  out  1  timer chipselect
tm_write_n  out  1  timer write, active-low
tm_writedata  out  16  timer write data
tm_readdata  in  16  timer read data, valid one cycle after read address
tm_irq  in  1  timer interrupt

Behaviour:
- Reset: busy=0, step_event=0, done=0, aborted=0, step_index=0, remaining=0, tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0, state IDLE. Table contents are not reset.
- Timer map: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4/5 snapshot l/h. Writes are zero-wait; one bus access per cycle; all tm_* outputs registered.
- start in IDLE with seq_len != 0: latch len = min(seq_len, NUM_STEPS) and loop_en, idx=0, busy=1, go to LOAD. start with seq_len=0, or while busy: ignored.
- LOAD: copy table[idx] into period shadow (protects against cfg_we tearing) -> WR_PL (addr 2, shadow[15:0]) -> WR_PH (addr 3, shadow[31:16]) -> GAP (no access; lets the timer's reload settle) -> WR_CTRL (addr 1, data 0x0005 = ITO|START) -> WAIT_IRQ.
- WAIT_IRQ: on tm_irq=1 -> CLR (addr 0 write, data 0) -> CLR_WAIT (one idle cycle; tm_irq is not sampled) -> ADVANCE.
- ADVANCE: pulse step_event with step_index=idx. If idx=len-1: loop_en=1 -> idx=0, LOAD; else pulse done same cycle, busy=0, IDLE. Otherwise idx+1, LOAD.
- Step duration: period P gives P+1 timer clocks from START to irq; P=0 is written unchanged (immediate timeout).
- stop in any non-IDLE state (honoured the following cycle; the access in flight completes): ABORT_STOP (addr 1, data 0x0008 = STOP, ITO=0) -> ABORT_CLR (addr 0 write) -> pulse aborted, busy=0, IDLE. No step_event or done for the aborted step. stop in IDLE: ignored.
- start and stop in the same cycle in IDLE: stop wins; stay IDLE.
- tm_irq arriving together with stop in WAIT_IRQ: abort wins.
- cfg_we: accepted in any state, single cycle. Takes effect at the next LOAD of that entry.
- Synchronous reset mid-sequence: outputs return to reset values next cycle. The timer is not re-programmed by this block.

Optional Feature:
TIMER_SEQ_SNAPSHOT_EN. Defined: the abort path inserts SNAP_WR (addr 4 write) -> SNAP_RL (read addr 4) -> SNAP_RH (read addr 5, capture low from tm_readdata) -> SNAP_CAP (capture high) before ABORT_STOP. remaining holds the captured 32-bit count until the next start, which clears it to 0. Not defined: those states are absent and remaining is tied to 0.

Test Plan:
- Table {10, 0x0001_0000}, seq_len=2, loop_en=0, start -> bus writes 2:0x000A, 3:0, gap, 1:0x0005; irq 11 clocks after START; clear write; step_event idx0, then idx1 with PH=0x0001; done pulse; busy=0.
- seq_len=3, loop_en=1, three 5-cycle steps -> step_index sequence 0,1,2,0,1; done never pulses; stop -> writes 1:0x0008 then 0:x; aborted pulse; no further step_event.
- seq_len=0 start -> no bus activity, busy stays 0. seq_len=12 with NUM_STEPS=8 -> 8 steps per pass.
- cfg_we to entry 1 during WR_PH of entry 1 -> timer receives the old PH; next pass uses the new value.
- start and stop same cycle in IDLE -> nothing. tm_irq and stop same cycle -> aborted, no step_event.
- TIMER_SEQ_SNAPSHOT_EN, period 100, stop 40 clocks after START -> remaining approx 60, exact count checked against the timer model; without macro remaining=0.

Source files
------------

// File: rtl/timer_step_sequencer_if.sv
// Avalon-MM link between the step sequencer (master)
// and the 16-bit interval timer slave.
interface timer_step_sequencer_if;
    logic [2:0]  tm_address;
    logic        tm_chipselect;
    logic        tm_write_n;
    logic [15:0] tm_writedata;
    logic [15:0] tm_readdata;
    logic        tm_irq;

    modport master (
        output tm_address, tm_chipselect, tm_write_n, tm_writedata,
        input  tm_readdata, tm_irq
    );

    modport slave (
        input  tm_address, tm_chipselect, tm_write_n, tm_writedata,
        output tm_readdata, tm_irq
    );
endinterface

// File: rtl/timer_step_sequencer.sv
// Sequences the interval timer through a table of one-shot periods.
// TIMER_SEQ_SNAPSHOT_EN: capture the remaining count on abort.
module timer_step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_index,
    input  logic [31:0]            cfg_period,
    input  logic [IDX_W:0]         seq_len,
    input  logic                   loop_en,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   step_event,
    output logic [IDX_W-1:0]       step_index,
    output logic                   done,
    output logic                   aborted,
    output logic [31:0]            remaining,
    timer_step_sequencer_if.master tm
);

    localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(NUM_STEPS);

    typedef enum logic [3:0] {
        IDLE, LOAD, WR_PL, WR_PH, GAP, WR_CTRL,
        WAIT_IRQ, CLR, CLR_WAIT, ADVANCE,
`ifdef TIMER_SEQ_SNAPSHOT_EN
        SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP,
`endif
        ABORT_STOP, ABORT_CLR
    } state_t;

`ifdef TIMER_SEQ_SNAPSHOT_EN
    localparam state_t ABORT_ENTRY = SNAP_WR;
`else
    localparam state_t ABORT_ENTRY = ABORT_STOP;
`endif

    state_t           state, state_n;
    logic [31:0]      table_q [NUM_STEPS];
    logic [31:0]      shadow;
    logic [IDX_W-1:0] idx, idx_n;
    logic [IDX_W:0]   len;
    logic             loop_q;
    logic             latch, last, in_abort, abort_go;
    logic             ev_step, ev_done, ev_abort;
    logic [2:0]       a_n;
    logic             cs_n, wn_n;
    logic [15:0]      d_n;

    always_ff @(posedge clk) begin
        if (cfg_we && 32'(cfg_index) < NUM_STEPS)
            table_q[cfg_index] <= cfg_period;
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    assign in_abort = state inside {SNAP_WR, SNAP_RL, SNAP_RH,
                                    SNAP_CAP, ABORT_STOP, ABORT_CLR};
`else
    assign in_abort = state inside {ABORT_STOP, ABORT_CLR};
`endif

    assign last     = ({1'b0, idx} == len - 1'b1);
    assign abort_go = stop && state != IDLE && !in_abort;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        latch    = 1'b0;
        ev_step  = 1'b0;
        ev_done  = 1'b0;
        ev_abort = 1'b0;
        unique case (state)
            IDLE:
                if (start && !stop && seq_len != '0) begin
                    latch   = 1'b1;
                    idx_n   = '0;
                    state_n = LOAD;
                end
            LOAD:     state_n = WR_PL;
            WR_PL:    state_n = WR_PH;
            WR_PH:    state_n = GAP;
            GAP:      state_n = WR_CTRL;
            WR_CTRL:  state_n = WAIT_IRQ;
            WAIT_IRQ: if (tm.tm_irq) state_n = CLR;
            CLR:      state_n = CLR_WAIT;
            CLR_WAIT: state_n = ADVANCE;
            ADVANCE: begin
                ev_step = 1'b1;
                if (!last) begin
                    idx_n   = idx + 1'b1;
                    state_n = LOAD;
                end else if (loop_q) begin
                    idx_n   = '0;
                    state_n = LOAD;
                end else begin
                    ev_done = 1'b1;
                    state_n = IDLE;
                end
            end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR:  state_n = SNAP_RL;
            SNAP_RL:  state_n = SNAP_RH;
            SNAP_RH:  state_n = SNAP_CAP;
            SNAP_CAP: state_n = ABORT_STOP;
`endif
            ABORT_STOP: state_n = ABORT_CLR;
            ABORT_CLR: begin
                ev_abort = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // abort overrides irq and the step/done pulses of this cycle
        if (abort_go) begin
            state_n = ABORT_ENTRY;
            idx_n   = idx;
            ev_step = 1'b0;
            ev_done = 1'b0;
        end
    end

    // bus registers track the state being entered
    always_comb begin
        a_n  = 3'd0;
        cs_n = 1'b0;
        wn_n = 1'b1;
        d_n  = 16'h0000;
        unique case (state_n)
            WR_PL: begin
                a_n = 3'd2; cs_n = 1'b1; wn_n = 1'b0;
                d_n = table_q[idx][15:0];
            end
            WR_PH: begin
                a_n = 3'd3; cs_n = 1'b1; wn_n = 1'b0;
                d_n = shadow[31:16];
            end
            WR_CTRL: begin
                a_n = 3'd1; cs_n = 1'b1; wn_n = 1'b0;
                d_n = 16'h0005;
            end
            CLR, ABORT_CLR: begin
                a_n = 3'd0; cs_n = 1'b1; wn_n = 1'b0;
            end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR: begin
                a_n = 3'd4; cs_n = 1'b1; wn_n = 1'b0;
            end
            SNAP_RL: begin
                a_n = 3'd4; cs_n = 1'b1;
            end
            SNAP_RH: begin
                a_n = 3'd5; cs_n = 1'b1;
            end
`endif
            ABORT_STOP: begin
                a_n = 3'd1; cs_n = 1'b1; wn_n = 1'b0;
                d_n = 16'h0008;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            len              <= '0;
            loop_q           <= 1'b0;
            shadow           <= '0;
            busy             <= 1'b0;
            step_event       <= 1'b0;
            step_index       <= '0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            tm.tm_address    <= 3'd0;
            tm.tm_chipselect <= 1'b0;
            tm.tm_write_n    <= 1'b1;
            tm.tm_writedata  <= 16'h0000;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            busy             <= (state_n != IDLE);
            step_event       <= ev_step;
            done             <= ev_done;
            aborted          <= ev_abort;
            tm.tm_address    <= a_n;
            tm.tm_chipselect <= cs_n;
            tm.tm_write_n    <= wn_n;
            tm.tm_writedata  <= d_n;
            if (latch) begin
                len    <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
                loop_q <= loop_en;
            end
            // shadow keeps a mid-load cfg_we from tearing the period
            if (state == LOAD) begin
                shadow     <= table_q[idx];
                step_index <= idx;
            end
        end
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [15:0] snap_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_lo   <= 16'h0000;
            remaining <= '0;
        end else begin
            if (latch)
                remaining <= '0;
            if (state == SNAP_RH)
                snap_lo <= tm.tm_readdata;
            if (state == SNAP_CAP)
                remaining <= {tm.tm_readdata, snap_lo};
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^tm.tm_readdata;
    assign remaining = '0;
`endif

endmodule
